// File: rtl/isa_types.sv
// Shared ISA-level types for the hart's data-memory interface:
// store control word, load funct3 codes, response bundle and responder FSM states.
package isa_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WW_BYTE = 2'b00,
    WW_HALF = 2'b01,
    WW_WORD = 2'b10
  } wwidth_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wenable;
    logic [XLEN-1:0] wdata;
    wwidth_e         wwidth;
  } mem_control_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
    logic            fault;
  } mem_resp_t;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } dmr_state_e;

  // Size code (00 byte, 01 half, 10 word) shared by wwidth and funct3[1:0].
  function automatic logic [2:0] width_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   width_bytes = 3'd1;
      2'b01:   width_bytes = 3'd2;
      2'b10:   width_bytes = 3'd4;
      default: width_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_legal = 1'b1;
      default:                             f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Hart <-> data-memory request/response bundle. The hart is the master,
// the memory responder is the slave.
interface data_mem_responder_if;
  import isa_types::*;

  logic                 req_valid;
  logic                 req_ready;
  mem_control_t         mem_ctrl;
  logic                 req_ren;
  logic [2:0]           req_funct3;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_data;
  logic                 resp_fault;

  modport master (
    output req_valid, mem_ctrl, req_ren, req_funct3,
    input  req_ready, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, mem_ctrl, req_ren, req_funct3,
    output req_ready, resp_valid, resp_data, resp_fault
  );

endinterface

// File: rtl/byte_lane_ram.sv
// Word-organised single-port RAM with per-byte write strobes and a registered
// read port. Contents are never reset.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/half/word loads and stores into a byte-lane RAM,
// splitting word-straddling accesses into two RAM cycles.
module data_mem_responder
  import isa_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int XLEN        = isa_types::XLEN
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmr_state_e state_q, state_d;

  // Request held for the high part of a spanning access.
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_store;
  logic [1:0]  lat_sz;

  // Response metadata, valid while the matching response is presented.
  logic        m_load, m_unsigned, m_span, m_lo_ok, m_hi_ok, pend_fault;
  logic [1:0]  m_off, m_sz;
  logic [31:0] lo_word_q;
  logic        resp_valid_q, resp_fault_q;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  // New request decode
  logic       req_ready, req_store, req_legal, accept;
  logic [1:0] req_sz;

  assign req_ready = (state_q == ST_IDLE);
  assign req_store = bus.mem_ctrl.wenable;
  assign req_sz    = req_store ? bus.mem_ctrl.wwidth : bus.req_funct3[1:0];
  assign req_legal = req_store ? (req_sz != 2'b11) : f3_legal(bus.req_funct3);
  assign accept    = bus.req_valid & req_ready & (req_store | bus.req_ren);

  // Operation currently driving the RAM: live request in IDLE, latched one in SECOND.
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_store;
  logic [1:0]  cur_sz;

  always_comb begin
    cur_addr  = bus.mem_ctrl.addr;
    cur_wdata = bus.mem_ctrl.wdata;
    cur_store = req_store;
    cur_sz    = req_sz;
    if (state_q == ST_SECOND) begin
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_store = lat_store;
      cur_sz    = lat_sz;
    end
  end

  logic [1:0]    off;
  logic [2:0]    nbytes;
  logic [3:0]    end_lane;
  logic          span, lo_ok, hi_ok;
  logic [29:0]   word_lo;
  logic [AW-1:0] word_hi;
  logic [3:0]    lo_mask, hi_mask;
  logic [63:0]   wide;

  assign off      = cur_addr[1:0];
  assign nbytes   = width_bytes(cur_sz);
  assign end_lane = {2'b00, off} + {1'b0, nbytes};   // one past the last lane touched
  assign span     = end_lane > 4'd4;
  assign word_lo  = cur_addr[31:2];
  assign word_hi  = word_lo[AW-1:0] + AW'(1);
  assign lo_ok    = {2'b00, word_lo} < DEPTH_WORDS;
  assign hi_ok    = ({2'b00, word_lo} + 32'd1) < DEPTH_WORDS;
  assign wide     = {32'b0, cur_wdata} << {off, 3'b000};

  always_comb begin
    lo_mask = '0;
    hi_mask = '0;
    for (int l = 0; l < 4; l++) begin
      lo_mask[l] = (4'(l) >= {2'b00, off}) && (4'(l) < end_lane);
      hi_mask[l] = 4'(l + 4) < end_lane;
    end
  end

  // FSM next state and RAM port control
  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && req_legal) begin
          ram_en    = 1'b1;
          ram_addr  = word_lo[AW-1:0];
          ram_we    = (cur_store && lo_ok) ? lo_mask : 4'b0;
          ram_wdata = wide[31:0];
          if (span) state_d = ST_SECOND;
        end
      end
      ST_SECOND: begin
        // Out-of-range high word keeps its strobes off so the index cannot wrap to word 0.
        ram_en    = 1'b1;
        ram_addr  = word_hi;
        ram_we    = (cur_store && hi_ok) ? hi_mask : 4'b0;
        ram_wdata = wide[63:32];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_store    <= 1'b0;
      lat_sz       <= '0;
      m_load       <= 1'b0;
      m_unsigned   <= 1'b0;
      m_span       <= 1'b0;
      m_lo_ok      <= 1'b0;
      m_hi_ok      <= 1'b0;
      m_off        <= '0;
      m_sz         <= '0;
      pend_fault   <= 1'b0;
      lo_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      if (state_q == ST_SECOND) begin
        resp_valid_q <= 1'b1;
        resp_fault_q <= pend_fault;
        lo_word_q    <= m_lo_ok ? ram_rdata : 32'b0;
      end else if (accept) begin
        lat_addr   <= bus.mem_ctrl.addr;
        lat_wdata  <= bus.mem_ctrl.wdata;
        lat_store  <= req_store;
        lat_sz     <= req_sz;
        m_load     <= !req_store && req_legal;
        m_unsigned <= bus.req_funct3[2];
        m_off      <= off;
        m_sz       <= req_sz;
        m_span     <= req_legal && span;
        m_lo_ok    <= lo_ok;
        m_hi_ok    <= hi_ok;
        if (!req_legal) begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b1;
        end else if (span) begin
          pend_fault <= !lo_ok || !hi_ok;
        end else begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= !lo_ok;
        end
      end
    end
  end

  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Load assembly: little-endian gather from low/high words, then extend.
  logic [XLEN-1:0] lo_w, hi_w, shifted, ext;

  assign lo_w    = m_span ? lo_word_q : (m_lo_ok ? ram_rdata : '0);
  assign hi_w    = (m_span && m_hi_ok) ? ram_rdata : '0;
  assign shifted = XLEN'({hi_w, lo_w} >> {m_off, 3'b000});

  always_comb begin
    ext = shifted;
    case (m_sz)
      2'b00:   ext = m_unsigned ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   ext = m_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  mem_resp_t resp;
  assign resp.valid = resp_valid_q;
  assign resp.data  = (resp_valid_q && m_load) ? ext : '0;
  assign resp.fault = resp_fault_q;

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp.valid;
  assign bus.resp_data  = resp.data;
  assign bus.resp_fault = resp.fault;

endmodule
